// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO store channel: decoder address and collector defaults.
package gpio_pkg;
    localparam logic [31:0] GPIO_ADDR      = 32'd33135;
    localparam int          DEF_BYTE_W     = 8;
    localparam int          DEF_FIFO_DEPTH = 4;
endpackage

// File: rtl/gpio_sync_fifo.sv
// Generic synchronous FIFO with registered storage and head word read at the read pointer.
// Latency: pushed word visible at head one cycle after the push edge (no fall-through).
// Backpressure: push ignored when full unless a pop happens on the same edge; pop ignored when empty.
module gpio_sync_fifo
    import gpio_pkg::*;
#(
    parameter int W     = DEF_BYTE_W,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head_dat
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    // One extra pointer bit separates full from empty; wrap is modulo 2*DEPTH.
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign head_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_dat;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end
endmodule

// File: rtl/gpio_byte_collector.sv
// Assembles GPIO bit strobes into words and buffers them behind a valid/ready port.
// Latency: completed or flushed word appears at out_data/out_valid one cycle after the edge.
// Backpressure: words arriving while the FIFO is full (and not popping) are dropped and flag overflow.
module gpio_byte_collector
    import gpio_pkg::*;
#(
    parameter int BYTE_W     = DEF_BYTE_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int MSB_FIRST  = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        gpio,
    input  logic                        gpio_flag,
    input  logic                        flush,
    output logic [BYTE_W-1:0]           out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(BYTE_W):0]     bit_count,
    output logic [15:0]                 word_count,
    output logic                        overflow
);
    localparam int CW = $clog2(BYTE_W) + 1;

    logic [BYTE_W-1:0] sr;
    logic [BYTE_W-1:0] sr_shift;
    logic [BYTE_W-1:0] push_dat;
    logic [CW-1:0]     cnt_eff;
    logic [CW-1:0]     shamt;
    logic              complete;
    logic              push;
    logic              pop;
    logic              wr;
    logic              full;
    logic              empty;

    always_comb begin
        sr_shift = sr;
        if (gpio_flag) begin
            sr_shift = (MSB_FIRST != 0) ? {sr[BYTE_W-2:0], gpio} : {gpio, sr[BYTE_W-1:1]};
        end
    end

    // A same-cycle strobe is absorbed before any flush decision.
    assign cnt_eff  = bit_count + CW'(gpio_flag);
    assign complete = (cnt_eff == CW'(BYTE_W));
    assign push     = complete || (flush && (cnt_eff != '0));

    // The register is cleared after every push, so shifting by the missing bit
    // count both aligns a partial word and zero-pads it; a full word shifts by 0.
    assign shamt    = CW'(BYTE_W) - cnt_eff;
    assign push_dat = (MSB_FIRST != 0) ? (sr_shift << shamt) : (sr_shift >> shamt);

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign wr        = push && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr         <= '0;
            bit_count  <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                sr        <= '0;
                bit_count <= '0;
            end else if (gpio_flag) begin
                sr        <= sr_shift;
                bit_count <= cnt_eff;
            end
            if (wr) begin
                word_count <= word_count + 16'd1;
            end else if (push) begin
                overflow <= 1'b1;
            end
        end
    end

    gpio_sync_fifo #(
        .W     (BYTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (wr),
        .push_dat (push_dat),
        .pop      (pop),
        .full     (full),
        .empty    (empty),
        .head_dat (out_data)
    );
endmodule

// File: tb/tb_gpio_byte_collector.sv
// Directed bench for gpio_byte_collector (BYTE_W=8, FIFO_DEPTH=4, MSB_FIRST=1).
module tb_gpio_byte_collector;
    logic        clk = 1'b0;
    logic        rst;
    logic        gpio;
    logic        gpio_flag;
    logic        flush;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  bit_count;
    logic [15:0] word_count;
    logic        overflow;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    gpio_byte_collector #(
        .BYTE_W     (8),
        .FIFO_DEPTH (4),
        .MSB_FIRST  (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .gpio       (gpio),
        .gpio_flag  (gpio_flag),
        .flush      (flush),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .bit_count  (bit_count),
        .word_count (word_count),
        .overflow   (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        gpio      = b;
        gpio_flag = 1'b1;
        tick();
        gpio_flag = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            send_bit(v[i]);
        end
    endtask

    initial begin
        logic [7:0] v;
        rst       = 1'b1;
        gpio      = 1'b1;
        gpio_flag = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Reset with strobes active: everything stays 0
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'h00);
        chk("rst_bitcnt", 32'(bit_count), 32'd0);
        chk("rst_wordcnt", 32'(word_count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        gpio_flag = 1'b0;
        rst       = 1'b0;
        tick();

        // Basic byte 0xB2 with out_ready held high
        out_ready = 1'b1;
        v = 8'hB2;
        for (int i = 7; i >= 1; i--) send_bit(v[i]);
        chk("basic_bitcnt7", 32'(bit_count), 32'd7);
        chk("basic_novalid", 32'(out_valid), 32'd0);
        send_bit(v[0]);
        chk("basic_valid", 32'(out_valid), 32'd1);
        chk("basic_data", 32'(out_data), 32'hB2);
        chk("basic_wordcnt", 32'(word_count), 32'd1);
        chk("basic_bitcnt0", 32'(bit_count), 32'd0);
        tick();
        chk("basic_popped", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Flush of 1,1,0 then a redundant flush
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        chk("flush_bitcnt3", 32'(bit_count), 32'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_data", 32'(out_data), 32'hC0);
        chk("flush_valid", 32'(out_valid), 32'd1);
        chk("flush_bitcnt", 32'(bit_count), 32'd0);
        chk("flush_wordcnt", 32'(word_count), 32'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush2_wordcnt", 32'(word_count), 32'd2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("flush2_empty", 32'(out_valid), 32'd0);

        // Flush with a strobe in the same cycle: bits 1,1 then strobe 0 + flush
        send_bit(1'b1);
        send_bit(1'b1);
        gpio      = 1'b0;
        gpio_flag = 1'b1;
        flush     = 1'b1;
        tick();
        gpio_flag = 1'b0;
        flush     = 1'b0;
        chk("flushstb_data", 32'(out_data), 32'hC0);
        chk("flushstb_wordcnt", 32'(word_count), 32'd3);
        chk("flushstb_bitcnt", 32'(bit_count), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Fill FIFO: 0x11, 0x22, then 16 back-to-back strobes of 1
        send_byte(8'h11);
        send_byte(8'h22);
        gpio      = 1'b1;
        gpio_flag = 1'b1;
        repeat (16) @(posedge clk);
        #1;
        gpio_flag = 1'b0;
        chk("b2b_wordcnt", 32'(word_count), 32'd7);
        chk("b2b_bitcnt", 32'(bit_count), 32'd0);
        chk("b2b_ovf", 32'(overflow), 32'd0);
        chk("b2b_head", 32'(out_data), 32'h11);

        // Push 0x33 while full with a pop on the same edge
        v = 8'h33;
        for (int i = 7; i >= 1; i--) send_bit(v[i]);
        out_ready = 1'b1;
        send_bit(v[0]);
        out_ready = 1'b0;
        chk("fullpp_ovf", 32'(overflow), 32'd0);
        chk("fullpp_wordcnt", 32'(word_count), 32'd8);
        chk("fullpp_head", 32'(out_data), 32'h22);
        out_ready = 1'b1;
        chk("drain1_0", 32'(out_data), 32'h22);
        tick();
        chk("drain1_1", 32'(out_data), 32'hFF);
        tick();
        chk("drain1_2", 32'(out_data), 32'hFF);
        tick();
        chk("drain1_3", 32'(out_data), 32'h33);
        tick();
        chk("drain1_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Overflow: five words into a depth-4 FIFO with no reader
        for (int w = 1; w <= 4; w++) send_byte(8'(w));
        chk("ovf_pre", 32'(overflow), 32'd0);
        chk("ovf_pre_wordcnt", 32'(word_count), 32'd12);
        send_byte(8'h05);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_wordcnt", 32'(word_count), 32'd12);
        out_ready = 1'b1;
        chk("drain2_0", 32'(out_data), 32'h01);
        tick();
        chk("drain2_1", 32'(out_data), 32'h02);
        tick();
        chk("drain2_2", 32'(out_data), 32'h03);
        tick();
        chk("drain2_3", 32'(out_data), 32'h04);
        tick();
        chk("drain2_empty", 32'(out_valid), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        out_ready = 1'b0;

        // Asynchronous reset mid-word with a word buffered
        send_byte(8'h77);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_data", 32'(out_data), 32'h00);
        chk("arst_bitcnt", 32'(bit_count), 32'd0);
        chk("arst_wordcnt", 32'(word_count), 32'd0);
        chk("arst_ovf", 32'(overflow), 32'd0);
        gpio      = 1'b1;
        gpio_flag = 1'b1;
        tick();
        chk("arst_strobe_ignored", 32'(bit_count), 32'd0);
        gpio_flag = 1'b0;
        rst       = 1'b0;
        tick();
        send_byte(8'h5A);
        chk("post_rst_data", 32'(out_data), 32'h5A);
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_wordcnt", 32'(word_count), 32'd1);
        chk("post_rst_bitcnt", 32'(bit_count), 32'd0);
        out_ready = 1'b1;
        tick();
        chk("post_rst_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/gpio_byte_collector.md
# gpio_byte_collector

Consumer end of the single-bit GPIO store channel. The memory segmentation decoder raises `GPIOFlag` with the data bit on `GPIO` when the processor stores to the GPIO address. This block samples those bit strobes, assembles them into bytes, and buffers the bytes in a small FIFO behind a valid/ready output port. It sits beside the pipeline processor, between the memory decoder and whatever drains GPIO output (the testbench file writer or an on-board sink).

## Interface
Parameters:
- `BYTE_W`, default 8: bits per assembled word.
- `FIFO_DEPTH`, default 4: number of buffered words; must be a power of 2 and at least 2.
- `MSB_FIRST`, default 1: 1 places the first received bit at bit `BYTE_W-1`; 0 places it at bit 0.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset; asynchronous, active-high.
- `gpio`, in, 1: data bit, valid when `gpio_flag`=1.
- `gpio_flag`, in, 1: bit strobe; each rising clock edge with `gpio_flag`=1 consumes one bit.
- `flush`, in, 1: emit the partial word, zero-padded.
- `out_data`, out, `BYTE_W`: FIFO head word.
- `out_valid`, out, 1: FIFO not empty.
- `out_ready`, in, 1: consumer accepts the head word this cycle.
- `bit_count`, out, `$clog2(BYTE_W)+1`: bits held in the partial word.
- `word_count`, out, 16: total words pushed; wraps from 0xFFFF to 0.
- `overflow`, out, 1: sticky; a word was dropped because the FIFO was full.

## Operation
- Reset value of every output is 0: `out_data`, `out_valid`, `bit_count`, `word_count`, `overflow`. Reset also clears the shift register and the FIFO pointers.
- Shift register:
  - `MSB_FIRST`=1: on each strobe, `sr <= {sr[BYTE_W-2:0], gpio}`.
  - `MSB_FIRST`=0: on each strobe, `sr <= {gpio, sr[BYTE_W-1:1]}`.
  - `bit_count` increments by 1 per strobe.
- Completion: when a strobe makes the bit count equal `BYTE_W`, the completed word is pushed on that same edge and `bit_count` returns to 0. The register is not left holding 8.
- Flush: when `flush`=1 and the effective count is greater than 0, push the partial word on that edge.
  - Effective count includes a strobe in the same cycle; that bit is taken first, then the flush.
  - `MSB_FIRST`=1: bits are left-aligned and the low bits are zero. Example: received bits 1,1,0 give 0xC0.
  - `MSB_FIRST`=0: bits are right-aligned and the high bits are zero.
  - `bit_count` returns to 0.
  - A flush with an effective count of 0 is a no-op.
- Push:
  - If the FIFO is not full, or a pop happens in the same cycle, write the word and increment `word_count`.
  - Otherwise drop the word, set `overflow`, and leave `word_count` unchanged.
  - `overflow` clears only on `rst`.
- Pop: occurs on an edge where `out_valid`=1 and `out_ready`=1. `out_ready` while empty is ignored.
- Simultaneous push and pop:
  - When full: both occur, and the FIFO stays full.
  - When empty: the push is written and `out_valid` rises after the edge. There is no fall-through.
- FIFO pointers are `$clog2(FIFO_DEPTH)+1` bits wide, which distinguishes full from empty. They wrap modulo 2·`FIFO_DEPTH`.
- `gpio_flag` held high for N consecutive cycles counts as N bits. The decoder's flag is one cycle per store in the MEM stage.
- `gpio` is ignored while `gpio_flag`=0.

## Timing
- The strobe is sampled at edge E.
  - If E completes a word, `out_valid` and `out_data` reflect it immediately after E, i.e. one cycle of latency.
  - This holds when the FIFO was empty. Otherwise the word waits behind earlier words.
- `out_data` is driven combinationally from the registered FIFO storage at the read pointer. It is stable while `out_valid`=1 and `out_ready`=0.
- Throughput: one word per `BYTE_W` strobes on the input side; one pop per cycle on the output side.
- Reset mid-word or mid-burst:
  - Asynchronous assertion immediately clears the partial word, the FIFO, and all counters.
  - After deassertion, the first strobe is bit 0 of a new word.
- There are no combinational paths from inputs to outputs.

## Structure
- Shared package `gpio_pkg`:
  - `GPIO_ADDR` = 32'd33135, the same constant the decoder uses.
  - Default `BYTE_W` and `FIFO_DEPTH` localparams.
- One sub-module: `gpio_sync_fifo`, parameterised by width and depth. It provides push, pop, full, empty and head data.
- The top level holds the shift register, the bit counter, flush alignment, `word_count` and the overflow logic.

## Test plan
- **Reset:** assert `rst` asynchronously between edges → all outputs 0 at once. Strobes during reset are ignored.
- **Basic byte:** bits 1,0,1,1,0,0,1,0 on consecutive strobes with `out_ready`=1 and `MSB_FIRST`=1 → `out_data`=0xB2 and `out_valid`=1 right after the 8th edge, `word_count`=1, `bit_count`=0.
- **Overflow:** `out_ready`=0, send words 0x01–0x05 with `FIFO_DEPTH`=4 → `overflow`=1 after the 5th word, `word_count`=4. Then draining yields 0x01, 0x02, 0x03, 0x04 and `out_valid` drops.
- **Flush:** bits 1,1,0 then `flush` → 0xC0, `bit_count`=0. A second flush pushes nothing.
- **Back-to-back strobes, full FIFO:** `gpio_flag`=1 and `gpio`=1 for 16 consecutive cycles → two 0xFF words. Push and pop in the same cycle while full → no overflow.
- **Reset mid-word:** `rst` after 5 bits, then 8 bits 0x5A → single word 0x5A, `word_count`=1.
